// File: rtl/tlc_pkg.sv
// Shared definitions for the actuated traffic-light phase scheduler:
// lamp codes, controller states, phase count and default timing.
package tlc_pkg;

    localparam int NUM_PHASES = 4;

    localparam logic [2:0] LAMP_GREEN  = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b001;

    localparam int DEF_MIN_GREEN   = 4;
    localparam int DEF_MAX_GREEN   = 12;
    localparam int DEF_YELLOW_TIME = 4;
    localparam int DEF_CLEAR_TIME  = 2;
    localparam int DEF_CW          = 5;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        ALLRED = 2'd2
    } tlc_state_e;

    function automatic logic [NUM_PHASES-1:0] phase_onehot(input logic [1:0] p);
        return NUM_PHASES'(1) << p;
    endfunction

endpackage

// File: rtl/tlc_phase_scheduler_if.sv
// Detector/preempt inputs and lamp/status outputs of the phase scheduler.
// master = the side driving detectors (controller host), slave = the scheduler.
interface tlc_phase_scheduler_if;
    import tlc_pkg::*;

    logic                      tick;
    logic [NUM_PHASES-1:0]     req;
    logic                      emg_req;
    logic [1:0]                emg_phase;
    logic [3*NUM_PHASES-1:0]   lights;
    logic [1:0]                cur_phase;
    logic                      phase_start;
    logic [NUM_PHASES-1:0]     pending;
    logic                      emg_active;

    modport master (
        output tick, req, emg_req, emg_phase,
        input  lights, cur_phase, phase_start, pending, emg_active
    );

    modport slave (
        input  tick, req, emg_req, emg_phase,
        output lights, cur_phase, phase_start, pending, emg_active
    );

endinterface

// File: rtl/tlc_rr_picker.sv
// Combinational round-robin picker: first set bit of pending searching
// upward from last+1 with wrap-around; last itself is examined last.
module tlc_rr_picker
    import tlc_pkg::*;
(
    input  logic [NUM_PHASES-1:0] pending,
    input  logic [1:0]            last,
    output logic [1:0]            next,
    output logic                  valid
);

    logic [1:0]            cand [NUM_PHASES];
    logic [NUM_PHASES-1:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PHASES; gi++) begin : g_cand
            assign cand[gi] = last + 2'(gi + 1);
            assign hit[gi]  = pending[cand[gi]];
        end
    endgenerate

    // Walk from the farthest candidate down so the nearest hit overrides.
    always_comb begin
        next  = last;
        valid = 1'b0;
        for (int i = NUM_PHASES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                next  = cand[i];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Actuated 4-phase scheduler: round-robin green among pending detector
// requests with min/max green, yellow and all-red clearance, plus preemption.
module tlc_phase_scheduler
    import tlc_pkg::*;
#(
    parameter int MIN_GREEN   = DEF_MIN_GREEN,
    parameter int MAX_GREEN   = DEF_MAX_GREEN,
    parameter int YELLOW_TIME = DEF_YELLOW_TIME,
    parameter int CLEAR_TIME  = DEF_CLEAR_TIME,
    parameter int CW          = DEF_CW
) (
    input  logic                 clk,
    input  logic                 reset_n,
    tlc_phase_scheduler_if.slave bus
);

    localparam logic [CW:0]   MIN_E    = (CW+1)'(MIN_GREEN);
    localparam logic [CW:0]   MAX_E    = (CW+1)'(MAX_GREEN);
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_GREEN);
    localparam logic [CW-1:0] YEL_LAST = CW'(YELLOW_TIME - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_TIME - 1);
    localparam logic [3*NUM_PHASES-1:0] RESET_LIGHTS =
        {{(NUM_PHASES-1){LAMP_RED}}, LAMP_GREEN};

    tlc_state_e              state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [1:0]              cur_phase_q, cur_phase_d;
    logic [NUM_PHASES-1:0]   pending_q, pending_d;
    logic                    phase_start_q, phase_start_d;
    logic                    emg_active_q, emg_active_d;
    logic [3*NUM_PHASES-1:0] lights_q, lights_d;

    logic [CW:0]             e_cnt;
    logic [CW-1:0]           cnt_sat;
    logic                    other;
    logic                    enter_green;
    logic [1:0]              pick_next;
    logic                    pick_valid;
    logic [1:0]              next_phase;
    logic [NUM_PHASES-1:0]   pending_set;
    logic [NUM_PHASES-1:0]   grant_mask;

    tlc_rr_picker u_picker (
        .pending (pending_q),
        .last    (cur_phase_q),
        .next    (pick_next),
        .valid   (pick_valid)
    );

    assign next_phase = pick_valid ? pick_next : cur_phase_q;
    assign other      = |(pending_q & ~phase_onehot(cur_phase_q));
    assign e_cnt      = {1'b0, cnt_q} + (CW+1)'(1);
    assign cnt_sat    = (e_cnt >= MAX_E) ? MAX_CNT : e_cnt[CW-1:0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= GREEN;
            cnt_q         <= '0;
            cur_phase_q   <= 2'd0;
            pending_q     <= '0;
            phase_start_q <= 1'b0;
            emg_active_q  <= 1'b0;
            lights_q      <= RESET_LIGHTS;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cur_phase_q   <= cur_phase_d;
            pending_q     <= pending_d;
            phase_start_q <= phase_start_d;
            emg_active_q  <= emg_active_d;
            lights_q      <= lights_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_phase_d = cur_phase_q;
        enter_green = 1'b0;

        case (state_q)
            GREEN: begin
                if (bus.emg_req) begin
                    // Preempt away from a non-selected green at once, no tick needed.
                    if (bus.emg_phase != cur_phase_q) begin
                        state_d = YELLOW;
                        cnt_d   = '0;
                    end else if (bus.tick) begin
                        cnt_d = cnt_sat;
                    end
                end else if (bus.tick) begin
                    if (other && (((e_cnt >= MIN_E) && !bus.req[cur_phase_q]) ||
                                  (e_cnt >= MAX_E))) begin
                        state_d = YELLOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_sat;
                    end
                end
            end

            YELLOW: begin
                if (bus.tick) begin
                    if (cnt_q == YEL_LAST) begin
                        state_d = ALLRED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            ALLRED: begin
                if (bus.tick) begin
                    if (cnt_q == CLR_LAST) begin
                        state_d     = GREEN;
                        cnt_d       = '0;
                        cur_phase_d = bus.emg_req ? bus.emg_phase : next_phase;
                        enter_green = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            default: begin
                state_d = GREEN;
                cnt_d   = '0;
            end
        endcase
    end

    // Requests are latched unless their phase is the one currently green;
    // the phase being granted has its bit cleared, winning over a new set.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PHASES; gi++) begin : g_pend
            assign pending_set[gi] = bus.req[gi] &&
                                     !((state_q == GREEN) && (cur_phase_q == 2'(gi)));
            assign grant_mask[gi]  = enter_green && (cur_phase_d == 2'(gi));
        end
    endgenerate

    assign pending_d     = (pending_q | pending_set) & ~grant_mask;
    assign phase_start_d = enter_green;

    // ------------------------------------------------------------------
    // Output logic: lamps follow the registered state one clk later
    // ------------------------------------------------------------------
    always_comb begin
        lights_d = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            lights_d[3*i +: 3] = LAMP_RED;
            if (cur_phase_q == 2'(i)) begin
                if (state_q == GREEN) begin
                    lights_d[3*i +: 3] = LAMP_GREEN;
                end else if (state_q == YELLOW) begin
                    lights_d[3*i +: 3] = LAMP_YELLOW;
                end
            end
        end
        emg_active_d = bus.emg_req;
    end

    assign bus.lights      = lights_q;
    assign bus.cur_phase   = cur_phase_q;
    assign bus.phase_start = phase_start_q;
    assign bus.pending     = pending_q;
    assign bus.emg_active  = emg_active_q;

endmodule
